strob_gen: RTL and testbench
============================

STROB_GEN -- requirements
Module: strob_gen

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 8'd200, bus-answer wait limit in clk_sys cycles (range 1..255).
REQ-002 SHALL provide clk_sys  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide clm  input  1  reset (clear master), synchronous, active-high.
REQ-004 SHALL provide start  input  1  request to begin one microcycle, sampled only in IDLE.
REQ-005 SHALL provide sl  input  1  long cycle select (strob1 and strob2 phases), sampled with start.
REQ-006 SHALL provide wm  input  1  cycle waits for system-bus answer after strob1, sampled with start.
REQ-007 SHALL provide stop  input  1  halt request; blocks acceptance of start.
REQ-008 SHALL provide ok  input  1  system-bus answer, honoured only in WAIT.
REQ-009 SHALL provide strob1, strob1b, strob2, strob2b  output  1 each  phase strobes to the P-R register unit.
REQ-010 SHALL provide as2  output  1  second-half flag (high in GOT, S2, S2B).
REQ-011 SHALL provide got  output  1  one-cycle pulse between phases of a long cycle.
REQ-012 SHALL provide busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL provide alarm  output  1  one-cycle pulse on bus-answer timeout.
REQ-014 SHALL provide done  output  1  one-cycle pulse in the cycle the FSM re-enters IDLE from S1B, WAIT or S2B.

Function
REQ-015 SHALL implement states IDLE, S1, S1B, WAIT, GOT, S2, S2B; all outputs are registered or decoded from the state register only (no combinational path from inputs).
REQ-016 IDLE: start=1 and stop=0 -> S1, latching sl into long_r and wm into wm_r; otherwise stay IDLE.
REQ-017 S1 -> S1B unconditionally; strob1=1 only in S1, strob1b=1 only in S1B.
REQ-018 S1B -> WAIT if wm_r; else GOT if long_r; else IDLE.
REQ-019 WAIT: ok=1 -> GOT if long_r, else IDLE; wait counter clears on WAIT entry and increments each WAIT cycle.
REQ-020 WAIT: counter reaching TIMEOUT with ok=0 -> alarm pulse (1 cycle) and same exit as ok=1.
REQ-021 ok and timeout in the same cycle -> ok wins, alarm stays 0.
REQ-022 GOT -> S2 -> S2B -> IDLE unconditionally; strob2=1 only in S2, strob2b=1 only in S2B.
REQ-023 Latency: start accepted at edge k -> strob1 high cycle k+1, strob1b k+2; short no-wait cycle done at k+3; long no-wait cycle got k+3, strob2 k+4, strob2b k+5, done k+6.
REQ-024 start, sl, wm changes while busy SHALL have no effect on the running cycle; ok outside WAIT ignored.
REQ-025 stop asserted while busy SHALL NOT abort the cycle; it only blocks the next start.
REQ-026 At most one strobe output SHALL be high in any cycle; as2 SHALL never be high with strob1/strob1b.
REQ-027 Counter is 8 bits, saturating, never wraps.

Reset
REQ-028 clm=1 at an edge SHALL force IDLE, long_r=wm_r=0, counter=0, all outputs 0 in the next cycle, regardless of state, and override start.
REQ-029 clm mid-cycle SHALL NOT produce done or alarm.

Verification
REQ-030 Short cycle: start=1,sl=0,wm=0 one cycle -> strob1, strob1b, done on consecutive cycles, as2 never 1.
REQ-031 Long cycle with bus: start,sl=1,wm=1; ok after 5 WAIT cycles -> strob1,strob1b,WAIT x5,got,strob2,strob2b,done; alarm 0.
REQ-032 Timeout: TIMEOUT=4, wm=1, ok never -> alarm pulse after 4 WAIT cycles, then got (sl=1) and strob2 sequence.
REQ-033 ok and timeout same cycle, plus ok pulses in IDLE/S2 -> no alarm, no state change from stray ok.
REQ-034 clm asserted in S2 and again in WAIT -> IDLE next cycle, all outputs 0, no done/alarm; stop=1 with start=1 -> no cycle begins until stop=0.

Source files
------------

// File: rtl/strob_gen_if.sv
// Bundles the microcycle request inputs and the phase strobe/status outputs of strob_gen.
// The master side drives the requests and the bus answer; the slave side drives the strobes.
interface strob_gen_if;
  logic start;
  logic sl;
  logic wm;
  logic stop;
  logic ok;
  logic strob1;
  logic strob1b;
  logic strob2;
  logic strob2b;
  logic as2;
  logic got;
  logic busy;
  logic alarm;
  logic done;

  modport master (
    output start, sl, wm, stop, ok,
    input  strob1, strob1b, strob2, strob2b, as2, got, busy, alarm, done
  );

  modport slave (
    input  start, sl, wm, stop, ok,
    output strob1, strob1b, strob2, strob2b, as2, got, busy, alarm, done
  );
endinterface

// File: rtl/strob_gen.sv
// Microcycle strobe sequencer: strob1/strob1b, an optional wait for the system-bus answer, then strob2/strob2b.
// A start accepted at edge k gives strob1 in cycle k+1. A running cycle cannot be aborted except by clm.
module strob_gen #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic         clk_sys,
  input  logic         clm,
  strob_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S1B  = 3'd2,
    WAIT = 3'd3,
    GOT  = 3'd4,
    S2   = 3'd5,
    S2B  = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic       long_r, long_nxt;
  logic       wm_r, wm_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       done_r, done_nxt;
  logic       alarm_r, alarm_nxt;
  logic       timeout;

  // The cycle in which the counter would reach TIMEOUT is the last WAIT cycle.
  assign timeout = (wait_cnt >= (TIMEOUT - 8'd1));

  always_ff @(posedge clk_sys) begin
    if (clm) begin
      state    <= IDLE;
      long_r   <= 1'b0;
      wm_r     <= 1'b0;
      wait_cnt <= 8'd0;
      done_r   <= 1'b0;
      alarm_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      long_r   <= long_nxt;
      wm_r     <= wm_nxt;
      wait_cnt <= wait_cnt_nxt;
      done_r   <= done_nxt;
      alarm_r  <= alarm_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    long_nxt     = long_r;
    wm_nxt       = wm_r;
    wait_cnt_nxt = wait_cnt;
    done_nxt     = 1'b0;
    alarm_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt = S1;
          long_nxt  = bus.sl;
          wm_nxt    = bus.wm;
        end
      end
      S1: state_nxt = S1B;
      S1B: begin
        if (wm_r) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 8'd0;
        end else if (long_r) begin
          state_nxt = GOT;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      WAIT: begin
        // ok has priority: a timeout in the same cycle raises no alarm.
        if (bus.ok || timeout) begin
          alarm_nxt = !bus.ok;
          if (long_r) begin
            state_nxt = GOT;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else if (wait_cnt != 8'hFF) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      GOT: state_nxt = S2;
      S2:  state_nxt = S2B;
      S2B: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.strob1  = (state == S1);
  assign bus.strob1b = (state == S1B);
  assign bus.strob2  = (state == S2);
  assign bus.strob2b = (state == S2B);
  assign bus.got     = (state == GOT);
  assign bus.as2     = (state == GOT) || (state == S2) || (state == S2B);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_r;
  assign bus.alarm   = alarm_r;

endmodule

// File: tb/tb_strob_gen.sv
// Directed bench for strob_gen: one default-TIMEOUT instance and one TIMEOUT=4 instance.
// Expected output vectors are queued with each stimulus step and compared after the edge.
module tb_strob_gen;

  // Output vector order: strob1 strob1b strob2 strob2b as2 got busy alarm done
  localparam logic [8:0] E_IDLE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_S1   = 9'b1_0_0_0_0_0_1_0_0;
  localparam logic [8:0] E_S1B  = 9'b0_1_0_0_0_0_1_0_0;
  localparam logic [8:0] E_WAIT = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] E_GOT  = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] E_GOTA = 9'b0_0_0_0_1_1_1_1_0;
  localparam logic [8:0] E_S2   = 9'b0_0_1_0_1_0_1_0_0;
  localparam logic [8:0] E_S2B  = 9'b0_0_0_1_1_0_1_0_0;
  localparam logic [8:0] E_DONE = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] E_DNA  = 9'b0_0_0_0_0_0_0_1_1;

  logic clk;
  logic clm, start, sl, wm, stop, ok, sel;
  logic [8:0] vec_a, vec_b;
  logic [8:0] sb[$];
  int checks, passes;

  strob_gen_if ifa ();
  strob_gen_if ifb ();

  assign ifa.start = start & ~sel;
  assign ifa.sl    = sl;
  assign ifa.wm    = wm;
  assign ifa.stop  = stop;
  assign ifa.ok    = ok;
  assign ifb.start = start & sel;
  assign ifb.sl    = sl;
  assign ifb.wm    = wm;
  assign ifb.stop  = stop;
  assign ifb.ok    = ok;

  assign vec_a = {ifa.strob1, ifa.strob1b, ifa.strob2, ifa.strob2b, ifa.as2,
                  ifa.got, ifa.busy, ifa.alarm, ifa.done};
  assign vec_b = {ifb.strob1, ifb.strob1b, ifb.strob2, ifb.strob2b, ifb.as2,
                  ifb.got, ifb.busy, ifb.alarm, ifb.done};

  strob_gen dut_a (.clk_sys(clk), .clm(clm), .bus(ifa));
  strob_gen #(.TIMEOUT(8'd4)) dut_b (.clk_sys(clk), .clm(clm), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic st, input logic s_l, input logic w_m, input logic sp,
                      input logic o_k, input logic c, input string tag, input logic [8:0] exp);
    logic [8:0] obs, e;
    start = st; sl = s_l; wm = w_m; stop = sp; ok = o_k; clm = c;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    obs = sel ? vec_b : vec_a;
    e = sb.pop_front();
    checks++;
    assert (obs === e) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, e);
  endtask

  initial begin
    checks = 0; passes = 0; sel = 1'b0;
    start = 0; sl = 0; wm = 0; stop = 0; ok = 0; clm = 0;

    // reset, with start held high to show clm overrides it
    step(1,1,1,0,0,1, "reset0", E_IDLE);
    step(1,1,1,0,0,1, "reset1", E_IDLE);
    step(0,0,0,0,0,0, "idle",   E_IDLE);

    // short cycle; busy-time changes to start/sl/wm must not matter
    step(1,0,0,0,0,0, "sh_s1",   E_S1);
    step(1,1,1,0,1,0, "sh_s1b",  E_S1B);
    step(1,1,1,0,0,0, "sh_done", E_DONE);
    step(0,0,0,0,0,0, "sh_idle", E_IDLE);

    // stray ok in IDLE
    step(0,0,0,0,1,0, "ok_idle", E_IDLE);

    // long cycle with bus wait, ok in 5th WAIT cycle; stray ok in S2
    step(1,1,1,0,0,0, "lb_s1",   E_S1);
    step(0,0,0,0,0,0, "lb_s1b",  E_S1B);
    step(0,0,0,0,0,0, "lb_w1",   E_WAIT);
    step(0,0,0,0,0,0, "lb_w2",   E_WAIT);
    step(1,0,0,0,0,0, "lb_w3",   E_WAIT);
    step(0,0,0,0,0,0, "lb_w4",   E_WAIT);
    step(0,0,0,0,0,0, "lb_w5",   E_WAIT);
    step(0,0,0,0,1,0, "lb_got",  E_GOT);
    step(0,0,0,0,0,0, "lb_s2",   E_S2);
    step(0,0,0,0,1,0, "lb_s2b",  E_S2B);
    step(0,0,0,0,0,0, "lb_done", E_DONE);
    step(0,0,0,0,0,0, "lb_idle", E_IDLE);

    // short cycle with wait; ok in S1/S1B ignored, ok in WAIT ends it
    step(1,0,1,0,0,0, "sw_s1",   E_S1);
    step(0,0,0,0,1,0, "sw_s1b",  E_S1B);
    step(0,0,0,0,1,0, "sw_w1",   E_WAIT);
    step(0,0,0,0,1,0, "sw_done", E_DONE);
    step(0,0,0,0,0,0, "sw_idle", E_IDLE);

    // stop blocks start; stop during a running cycle does not abort it
    step(1,0,0,1,0,0, "stop0",    E_IDLE);
    step(1,0,0,1,0,0, "stop1",    E_IDLE);
    step(1,1,0,0,0,0, "st_s1",    E_S1);
    step(0,0,0,1,0,0, "st_s1b",   E_S1B);
    step(0,0,0,1,0,0, "st_got",   E_GOT);
    step(0,0,0,1,0,0, "st_s2",    E_S2);
    step(0,0,0,1,0,0, "st_s2b",   E_S2B);
    step(0,0,0,1,0,0, "st_done",  E_DONE);
    step(1,0,0,1,0,0, "st_block", E_IDLE);
    step(0,0,0,0,0,0, "st_idle",  E_IDLE);

    // clm in S2
    step(1,1,0,0,0,0, "c2_s1",   E_S1);
    step(0,0,0,0,0,0, "c2_s1b",  E_S1B);
    step(0,0,0,0,0,0, "c2_got",  E_GOT);
    step(0,0,0,0,0,0, "c2_s2",   E_S2);
    step(1,0,0,0,0,1, "c2_clm",  E_IDLE);
    step(0,0,0,0,0,0, "c2_after", E_IDLE);

    // clm in WAIT
    step(1,1,1,0,0,0, "cw_s1",   E_S1);
    step(0,0,0,0,0,0, "cw_s1b",  E_S1B);
    step(0,0,0,0,0,0, "cw_w1",   E_WAIT);
    step(0,0,0,0,0,1, "cw_clm",  E_IDLE);
    step(0,0,0,0,0,0, "cw_after", E_IDLE);

    // TIMEOUT=4 instance
    sel = 1'b1;
    step(0,0,0,0,0,0, "b_idle", E_IDLE);

    // long cycle, ok never: alarm after 4 WAIT cycles, then strob2 phases
    step(1,1,1,0,0,0, "to_s1",   E_S1);
    step(0,0,0,0,0,0, "to_s1b",  E_S1B);
    step(0,0,0,0,0,0, "to_w1",   E_WAIT);
    step(0,0,0,0,0,0, "to_w2",   E_WAIT);
    step(0,0,0,0,0,0, "to_w3",   E_WAIT);
    step(0,0,0,0,0,0, "to_w4",   E_WAIT);
    step(0,0,0,0,0,0, "to_gota", E_GOTA);
    step(0,0,0,0,0,0, "to_s2",   E_S2);
    step(0,0,0,0,0,0, "to_s2b",  E_S2B);
    step(0,0,0,0,0,0, "to_done", E_DONE);
    step(0,0,0,0,0,0, "to_idle", E_IDLE);

    // ok coincides with the timeout cycle: no alarm
    step(1,0,1,0,0,0, "oc_s1",   E_S1);
    step(0,0,0,0,0,0, "oc_s1b",  E_S1B);
    step(0,0,0,0,0,0, "oc_w1",   E_WAIT);
    step(0,0,0,0,0,0, "oc_w2",   E_WAIT);
    step(0,0,0,0,0,0, "oc_w3",   E_WAIT);
    step(0,0,0,0,0,0, "oc_w4",   E_WAIT);
    step(0,0,0,0,1,0, "oc_done", E_DONE);
    step(0,0,0,0,0,0, "oc_idle", E_IDLE);

    // short cycle timeout: alarm coincides with done
    step(1,0,1,0,0,0, "ts_s1",   E_S1);
    step(0,0,0,0,0,0, "ts_s1b",  E_S1B);
    step(0,0,0,0,0,0, "ts_w1",   E_WAIT);
    step(0,0,0,0,0,0, "ts_w2",   E_WAIT);
    step(0,0,0,0,0,0, "ts_w3",   E_WAIT);
    step(0,0,0,0,0,0, "ts_w4",   E_WAIT);
    step(0,0,0,0,0,0, "ts_dna",  E_DNA);
    step(0,0,0,0,0,0, "ts_idle", E_IDLE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
